// File: rtl/lb_pkg.sv
// Shared types and defaults for the line buffer controller: FSM encoding,
// coordinate width and the window border test.
package lb_pkg;

    localparam int COORD_W = 11;
    localparam int FLUSH_W = 12;

    localparam int DEFAULT_PIC_WIDTH  = 250;
    localparam int DEFAULT_PIC_HEIGHT = 250;
    localparam int DEFAULT_RADIUS     = 2;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FIFO_RST  = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_RUN       = 3'd3,
        ST_FLUSH     = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    // True when the window centre is closer than rad to any frame edge.
    function automatic logic is_border(input coord_t row,
                                       input coord_t col,
                                       input coord_t rad,
                                       input coord_t row_hi,
                                       input coord_t col_hi);
        return (row < rad) || (row >= row_hi) || (col < rad) || (col >= col_hi);
    endfunction

endpackage

// File: rtl/pix_pos_cnt.sv
// Column/row position counter: column wraps at PIC_WIDTH-1, row advances on
// each wrap. Used for both the input and the window (output) position.
module pix_pos_cnt
    import lb_pkg::*;
#(
    parameter int PIC_WIDTH = DEFAULT_PIC_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               inc_i,
    output logic [COORD_W-1:0] col_o,
    output logic [COORD_W-1:0] row_o
);

    localparam coord_t COL_LAST = coord_t'(PIC_WIDTH - 1);

    coord_t col_q, col_d;
    coord_t row_q, row_d;

    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latch.
        col_d = col_q;
        row_d = row_q;
        if (clr_i) begin
            col_d = '0;
            row_d = '0;
        end else if (inc_i) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + coord_t'(1);
            end else begin
                col_d = col_q + coord_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            // NOTE: non-blocking so all flops update together on the edge.
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_o = col_q;
    assign row_o = row_q;

endmodule

// File: rtl/line_buffer_ctrl.sv
// Frame sequencer between a pixel source and a 5x5 line buffer: resets the
// FIFOs, gates pixel acceptance, flushes the last RADIUS lines, and tracks the
// window centre coordinate and border flag.
module line_buffer_ctrl
    import lb_pkg::*;
#(
    parameter int PIC_WIDTH  = DEFAULT_PIC_WIDTH,
    parameter int PIC_HEIGHT = DEFAULT_PIC_HEIGHT,
    parameter int RST_CYCLES = 8,
    parameter int RADIUS     = DEFAULT_RADIUS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        valid_in,
    output logic        ready,
    input  logic        fifo_rst_busy,
    output logic        rst_fifo,
    output logic        lb_valid,
    output logic        rd_en_all,
    output logic        win_valid,
    output logic [10:0] win_row,
    output logic [10:0] win_col,
    output logic        win_border,
    output logic        busy,
    output logic        frame_done
);

    localparam coord_t COL_LAST = coord_t'(PIC_WIDTH - 1);
    localparam coord_t ROW_LAST = coord_t'(PIC_HEIGHT - 1);
    localparam coord_t RAD_C    = coord_t'(RADIUS);
    localparam coord_t ROW_HI   = coord_t'(PIC_HEIGHT - RADIUS);
    localparam coord_t COL_HI   = coord_t'(PIC_WIDTH - RADIUS);

    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(RADIUS * PIC_WIDTH - 1);
    localparam logic [7:0]         RST_LAST   = 8'(RST_CYCLES - 1);

    state_t               state_q;
    logic [7:0]           rst_cnt_q;
    logic [FLUSH_W-1:0]   flush_cnt_q;
    logic                 rst_fifo_q;
    logic                 ready_q;
    logic                 rd_en_all_q;
    logic                 busy_q;
    logic                 frame_done_q;

    logic                 win_valid_q;
    coord_t               win_row_q;
    coord_t               win_col_q;
    logic                 win_border_q;

    coord_t               in_col, in_row;
    coord_t               out_col, out_row;

    logic                 accept;
    logic                 frame_go;
    logic                 in_last;
    logic                 tick;

    assign accept   = valid_in && ready_q;
    assign frame_go = (state_q == ST_IDLE) && frame_start;
    assign in_last  = accept && (in_row == ROW_LAST) && (in_col == COL_LAST);

    // The first RADIUS lines only prime the buffer; every flush cycle then
    // releases one of the centres still held back, so a frame yields W*H ticks.
    assign tick = (accept && (in_row >= RAD_C)) || rd_en_all_q;

    pix_pos_cnt #(
        .PIC_WIDTH(PIC_WIDTH)
    ) u_in_pos (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (frame_go),
        .inc_i (accept),
        .col_o (in_col),
        .row_o (in_row)
    );

    pix_pos_cnt #(
        .PIC_WIDTH(PIC_WIDTH)
    ) u_out_pos (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (frame_go),
        .inc_i (tick),
        .col_o (out_col),
        .row_o (out_row)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rst_cnt_q    <= '0;
            flush_cnt_q  <= '0;
            rst_fifo_q   <= 1'b1;
            ready_q      <= 1'b0;
            rd_en_all_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        state_q    <= ST_FIFO_RST;
                        rst_cnt_q  <= '0;
                        rst_fifo_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_FIFO_RST: begin
                    if (rst_cnt_q == RST_LAST) begin
                        state_q    <= ST_WAIT_BUSY;
                        rst_fifo_q <= 1'b1;
                    end else begin
                        rst_cnt_q  <= rst_cnt_q + 8'd1;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (!fifo_rst_busy) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (in_last) begin
                        state_q     <= ST_FLUSH;
                        ready_q     <= 1'b0;
                        rd_en_all_q <= 1'b1;
                        flush_cnt_q <= '0;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == FLUSH_LAST) begin
                        state_q      <= ST_DONE;
                        rd_en_all_q  <= 1'b0;
                        frame_done_q <= 1'b1;
                    end else begin
                        flush_cnt_q  <= flush_cnt_q + FLUSH_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    rst_fifo_q  <= 1'b1;
                    ready_q     <= 1'b0;
                    rd_en_all_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Window outputs trail the tick by one cycle to match the FIFO read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid_q  <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            win_border_q <= 1'b0;
        end else begin
            win_valid_q <= tick;
            if (tick) begin
                win_row_q    <= out_row;
                win_col_q    <= out_col;
                win_border_q <= is_border(out_row, out_col, RAD_C, ROW_HI, COL_HI);
            end
        end
    end

    assign ready      = ready_q;
    assign lb_valid   = accept;
    assign rst_fifo   = rst_fifo_q;
    assign rd_en_all  = rd_en_all_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign win_valid  = win_valid_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign win_border = win_border_q;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl on an 8x6 frame with a 5x5 window.
module tb_line_buffer_ctrl;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int RC = 4;
    localparam int R  = 2;

    logic        clk;
    logic        rst_n;
    logic        frame_start;
    logic        valid_in;
    logic        fifo_rst_busy;
    logic        ready;
    logic        rst_fifo;
    logic        lb_valid;
    logic        rd_en_all;
    logic        win_valid;
    logic [10:0] win_row;
    logic [10:0] win_col;
    logic        win_border;
    logic        busy;
    logic        frame_done;

    int tests_run    = 0;
    int tests_failed = 0;

    // Statistics gathered by the monitor, cleared per scenario.
    int  wv_cnt, rd_cnt, rd_runs, fd_cnt, acc_cnt, rst_low_cnt;
    int  coord_errs, border_errs, nb_cnt, tick_err, lbv_err, first_wv_acc;
    int  exp_r, exp_c;
    bit  prev_idle, prev_rd;

    line_buffer_ctrl #(
        .PIC_WIDTH (W),
        .PIC_HEIGHT(H),
        .RST_CYCLES(RC),
        .RADIUS    (R)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_start  (frame_start),
        .valid_in     (valid_in),
        .ready        (ready),
        .fifo_rst_busy(fifo_rst_busy),
        .rst_fifo     (rst_fifo),
        .lb_valid     (lb_valid),
        .rd_en_all    (rd_en_all),
        .win_valid    (win_valid),
        .win_row      (win_row),
        .win_col      (win_col),
        .win_border   (win_border),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (win_valid) begin
                bit b;
                if (wv_cnt == 0) first_wv_acc = acc_cnt;
                if (win_row !== 11'(exp_r) || win_col !== 11'(exp_c)) coord_errs++;
                b = (exp_r < R) || (exp_r >= H - R) || (exp_c < R) || (exp_c >= W - R);
                if (win_border !== b) border_errs++;
                if (win_border === 1'b0) nb_cnt++;
                if (prev_idle) tick_err++;
                wv_cnt++;
                if (exp_c == W - 1) begin
                    exp_c = 0;
                    exp_r++;
                end else begin
                    exp_c++;
                end
            end
            prev_idle = ready && !valid_in;
            if (lb_valid) acc_cnt++;
            if (lb_valid && !ready) lbv_err++;
            if (rd_en_all) begin
                rd_cnt++;
                if (!prev_rd) rd_runs++;
                if (lb_valid) lbv_err++;
            end
            prev_rd = rd_en_all;
            if (frame_done) fd_cnt++;
            if (!rst_fifo) rst_low_cnt++;
        end
    end

    task automatic clear_stats();
        wv_cnt = 0; rd_cnt = 0; rd_runs = 0; fd_cnt = 0; acc_cnt = 0; rst_low_cnt = 0;
        coord_errs = 0; border_errs = 0; nb_cnt = 0; tick_err = 0; lbv_err = 0;
        first_wv_acc = -1; exp_r = 0; exp_c = 0; prev_idle = 0; prev_rd = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulses frame_start and models the FIFO reset-busy handshake.
    task automatic start_frame(input int busy_hold);
        frame_start   = 1'b1;
        fifo_rst_busy = 1'b1;
        step();
        frame_start = 1'b0;
        for (int i = 0; i < 600 && rst_fifo !== 1'b1; i++) step();
        if (rst_fifo !== 1'b1) begin
            tests_run++; tests_failed++;
            $display("FAIL start_rst_fifo_timeout: rst_fifo=%b, expected 1", rst_fifo);
        end
        for (int i = 0; i < busy_hold; i++) step();
        fifo_rst_busy = 1'b0;
        for (int i = 0; i < 20 && ready !== 1'b1; i++) step();
        if (ready !== 1'b1) begin
            tests_run++; tests_failed++;
            $display("FAIL start_ready_timeout: ready=%b, expected 1", ready);
        end
    endtask

    task automatic feed_pixels(input int n, input int pct, input bit inject_fs);
        int sent = 0;
        int cyc  = 0;
        while (sent < n && cyc < 2000) begin
            valid_in    = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
            frame_start = inject_fs && (sent == 10);
            if (valid_in && ready) sent++;
            step();
            cyc++;
        end
        valid_in    = 1'b0;
        frame_start = 1'b0;
        if (sent < n) begin
            tests_run++; tests_failed++;
            $display("FAIL feed_timeout: accepted %0d pixels, expected %0d", sent, n);
        end
    endtask

    // Holds valid_in high through the flush to prove it is ignored there.
    task automatic finish_frame(input bit inject_fs);
        int cyc = 0;
        valid_in = 1'b1;
        while (cyc < 200 && fd_cnt == 0) begin
            frame_start = inject_fs && (cyc == 3);
            step();
            cyc++;
        end
        frame_start = 1'b0;
        valid_in    = 1'b0;
        if (fd_cnt == 0) begin
            tests_run++; tests_failed++;
            $display("FAIL frame_done_timeout: frame_done never seen, expected a pulse");
        end
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; frame_start = 1'b0; valid_in = 1'b1; fifo_rst_busy = 1'b1;
        #12;
        tests_run++;
        if ({rst_fifo, ready, rd_en_all, win_valid, win_border, busy, frame_done, lb_valid} !== 8'b1000_0000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b, expected 10000000",
                     {rst_fifo, ready, rd_en_all, win_valid, win_border, busy, frame_done, lb_valid});
        end
        tests_run++;
        if (win_row !== 11'd0 || win_col !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_coord: got (%0d,%0d), expected (0,0)", win_row, win_col);
        end
        @(negedge clk);
        rst_n = 1'b1; valid_in = 1'b0;
        repeat (5) step();
        tests_run++;
        if (busy !== 1'b0 || rst_fifo !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_no_autostart: busy=%b rst_fifo=%b, expected busy=0 rst_fifo=1", busy, rst_fifo);
        end
    endtask

    task automatic test_startup();
        clear_stats();
        frame_start = 1'b1; fifo_rst_busy = 1'b1;
        step();
        frame_start = 1'b0;
        tests_run++;
        if (rst_fifo !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL startup_enter: rst_fifo=%b busy=%b, expected 0 and 1", rst_fifo, busy);
        end
        for (int i = 0; i < 50 && rst_fifo !== 1'b1; i++) step();
        tests_run++;
        if (rst_low_cnt !== RC) begin
            tests_failed++;
            $display("FAIL startup_rst_len: rst_fifo low %0d cycles, expected %0d", rst_low_cnt, RC);
        end
        for (int i = 0; i < 10; i++) step();
        tests_run++;
        if (ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL startup_wait_busy: ready=%b, expected 0", ready);
        end
        fifo_rst_busy = 1'b0;
        step();
        tests_run++;
        if (ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL startup_ready: ready=%b, expected 1", ready);
        end
        feed_pixels(W * H, 100, 1'b0);
        finish_frame(1'b0);
    endtask

    task automatic test_continuous();
        clear_stats();
        start_frame(2);
        feed_pixels(W * H, 100, 1'b0);
        finish_frame(1'b0);
        tests_run++;
        if (first_wv_acc !== R * W + 1) begin
            tests_failed++;
            $display("FAIL cont_first_win: first win_valid after %0d accepts, expected %0d", first_wv_acc, R * W + 1);
        end
        tests_run++;
        if (rd_cnt !== R * W || rd_runs !== 1) begin
            tests_failed++;
            $display("FAIL cont_flush: rd_en_all %0d cycles in %0d runs, expected %0d in 1", rd_cnt, rd_runs, R * W);
        end
        tests_run++;
        if (wv_cnt !== W * H) begin
            tests_failed++;
            $display("FAIL cont_win_count: got %0d, expected %0d", wv_cnt, W * H);
        end
        tests_run++;
        if (fd_cnt !== 1) begin
            tests_failed++;
            $display("FAIL cont_frame_done: high %0d cycles, expected 1", fd_cnt);
        end
        tests_run++;
        if (acc_cnt !== W * H || lbv_err !== 0) begin
            tests_failed++;
            $display("FAIL cont_lb_valid: accepts=%0d stray=%0d, expected %0d and 0", acc_cnt, lbv_err, W * H);
        end
        tests_run++;
        if (coord_errs !== 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL cont_coord_idle: coord_errs=%0d busy=%b, expected 0 and 0", coord_errs, busy);
        end
    endtask

    task automatic test_gapped();
        clear_stats();
        start_frame(3);
        feed_pixels(W * H, 50, 1'b0);
        finish_frame(1'b0);
        tests_run++;
        if (wv_cnt !== W * H || coord_errs !== 0) begin
            tests_failed++;
            $display("FAIL gap_coords: %0d windows with %0d coord errors, expected %0d and 0", wv_cnt, coord_errs, W * H);
        end
        tests_run++;
        if (exp_r !== H || exp_c !== 0) begin
            tests_failed++;
            $display("FAIL gap_end_pos: model ended at (%0d,%0d), expected (%0d,0)", exp_r, exp_c, H);
        end
        tests_run++;
        if (tick_err !== 0) begin
            tests_failed++;
            $display("FAIL gap_idle_tick: %0d windows after idle cycles, expected 0", tick_err);
        end
        tests_run++;
        if (border_errs !== 0) begin
            tests_failed++;
            $display("FAIL border_flags: %0d wrong flags, expected 0", border_errs);
        end
        tests_run++;
        if (nb_cnt !== 8) begin
            tests_failed++;
            $display("FAIL border_interior: %0d non-border pixels, expected 8", nb_cnt);
        end
    endtask

    task automatic test_mid_reset();
        clear_stats();
        start_frame(2);
        feed_pixels(20, 100, 1'b0);
        valid_in = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({rst_fifo, ready, rd_en_all, win_valid, win_border, busy, frame_done, lb_valid} !== 8'b1000_0000) begin
            tests_failed++;
            $display("FAIL midrst_flags: got %b, expected 10000000",
                     {rst_fifo, ready, rd_en_all, win_valid, win_border, busy, frame_done, lb_valid});
        end
        tests_run++;
        if (win_row !== 11'd0 || win_col !== 11'd0) begin
            tests_failed++;
            $display("FAIL midrst_coord: got (%0d,%0d), expected (0,0)", win_row, win_col);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; valid_in = 1'b0;
        clear_stats();
        repeat (5) step();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_idle: busy=%b, expected 0", busy);
        end
        start_frame(2);
        feed_pixels(W * H, 100, 1'b0);
        finish_frame(1'b0);
        tests_run++;
        if (wv_cnt !== W * H || coord_errs !== 0 || fd_cnt !== 1) begin
            tests_failed++;
            $display("FAIL midrst_frame: windows=%0d errs=%0d done=%0d, expected %0d, 0, 1",
                     wv_cnt, coord_errs, fd_cnt, W * H);
        end
    endtask

    task automatic test_frame_start_ignored();
        clear_stats();
        start_frame(2);
        feed_pixels(W * H, 100, 1'b1);
        finish_frame(1'b1);
        tests_run++;
        if (rst_low_cnt !== RC) begin
            tests_failed++;
            $display("FAIL fs_no_rereset: rst_fifo low %0d cycles, expected %0d", rst_low_cnt, RC);
        end
        tests_run++;
        if (wv_cnt !== W * H || coord_errs !== 0) begin
            tests_failed++;
            $display("FAIL fs_windows: %0d windows, %0d errs, expected %0d and 0", wv_cnt, coord_errs, W * H);
        end
        tests_run++;
        if (rd_cnt !== R * W || fd_cnt !== 1 || acc_cnt !== W * H) begin
            tests_failed++;
            $display("FAIL fs_counts: rd=%0d done=%0d acc=%0d, expected %0d, 1, %0d",
                     rd_cnt, fd_cnt, acc_cnt, R * W, W * H);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL fs_back_idle: busy=%b, expected 0", busy);
        end
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_startup();
        test_continuous();
        test_gapped();
        test_mid_reset();
        test_frame_start_ignored();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
